// File: rtl/conv_window_gen_if.sv
// Pixel stream into conv_window_gen: one beat per cycle with pix_valid high, sof marks pixel (0,0).
// There is no ready: the slave accepts every beat, and sof is ignored unless pix_valid is also high.
interface conv_window_gen_if #(
    parameter int IMA = 8
);
    logic [IMA-1:0] pix_in;
    logic           pix_valid;
    logic           sof;

    modport master (output pix_in, output pix_valid, output sof);
    modport slave  (input  pix_in, input  pix_valid, input  sof);
endinterface

// File: rtl/conv_window_gen.sv
// Sliding KxK window generator: K-1 line buffers feed a KxK shift window, one window per complete beat.
// Optional macro CONV_WIN_STRIDE2_EN: only windows at even output row and column are emitted.
module conv_window_gen #(
    parameter int IMA   = 8,
    parameter int K     = 7,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic               clk,
    input  logic               rst_n,
    conv_window_gen_if.slave   pix,
    output logic [IMA*K*K-1:0] ima,
    output logic               enable,
    output logic [15:0]        out_row,
    output logic [15:0]        out_col,
    output logic               frame_done,
    output logic [1:0]         state_dbg
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [15:0] LAST_ROW = 16'(IMG_H - 1);
    localparam logic [15:0] LAST_COL = 16'(IMG_W - 1);
    localparam logic [15:0] KM1      = 16'(K - 1);
`ifdef CONV_WIN_STRIDE2_EN
    localparam logic [15:0] LAST_OROW = 16'(((IMG_H - K) / 2) * 2);
    localparam logic [15:0] LAST_OCOL = 16'(((IMG_W - K) / 2) * 2);
`else
    localparam logic [15:0] LAST_OROW = 16'(IMG_H - K);
    localparam logic [15:0] LAST_OCOL = 16'(IMG_W - K);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        row_q, row_d, col_q, col_d;
    logic [15:0]        out_row_q, out_row_d, out_col_q, out_col_d;
    logic               enable_q, enable_d, frame_done_q, frame_done_d;
    logic [IMA*K*K-1:0] ima_q, ima_d;
    logic [IMA-1:0]     linebuf_q [K-1][IMG_W];
    logic [IMA-1:0]     linebuf_d [K-1][IMG_W];
    logic [IMA-1:0]     win_q [K][K];
    logic [IMA-1:0]     win_d [K][K];

    logic               accept, last_pix, complete, stride_ok;
    logic [15:0]        cur_row, cur_col, orow, ocol;
    logic [CW-1:0]      col_idx;

    // cur_row/cur_col is the position of the beat on the bus; row_q/col_q is where the next beat lands.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        accept  = 1'b0;
        cur_row = row_q;
        cur_col = col_q;
        if (pix.pix_valid) begin
            if (state_q == S_RUN) accept = 1'b1;
            else                  accept = pix.sof;
            if (pix.sof) begin
                cur_row = '0;
                cur_col = '0;
            end
        end
        last_pix = accept && (cur_row == LAST_ROW) && (cur_col == LAST_COL);
        if (accept) begin
            if (last_pix) begin
                state_d = S_DONE;
                row_d   = '0;
                col_d   = '0;
            end else begin
                state_d = S_RUN;
                if (cur_col == LAST_COL) begin
                    col_d = '0;
                    row_d = cur_row + 16'd1;
                end else begin
                    col_d = cur_col + 16'd1;
                    row_d = cur_row;
                end
            end
        end
    end

    assign col_idx = cur_col[CW-1:0];

    always_comb begin
        linebuf_d = linebuf_q;
        win_d     = win_q;
        if (accept) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) win_d[r][c] = win_q[r][c+1];
            end
            for (int r = 0; r < K - 1; r++) win_d[r][K-1] = linebuf_q[r][col_idx];
            win_d[K-1][K-1] = pix.pix_in;
            for (int r = 0; r < K - 2; r++) linebuf_d[r][col_idx] = linebuf_q[r+1][col_idx];
            linebuf_d[K-2][col_idx] = pix.pix_in;
        end
    end

    // A window is only whole once the last K beats sat in one row and K rows have been seen.
    always_comb begin
        orow     = cur_row - KM1;
        ocol     = cur_col - KM1;
        complete = accept && (cur_row >= KM1) && (cur_col >= KM1);
`ifdef CONV_WIN_STRIDE2_EN
        stride_ok = ~orow[0] & ~ocol[0];
`else
        stride_ok = 1'b1;
`endif
        enable_d     = complete && stride_ok;
        frame_done_d = enable_d && (orow == LAST_OROW) && (ocol == LAST_OCOL);
        out_row_d    = out_row_q;
        out_col_d    = out_col_q;
        ima_d        = ima_q;
        if (enable_d) begin
            out_row_d = orow;
            out_col_d = ocol;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) ima_d[IMA*(r*K+c) +: IMA] = win_d[r][c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            col_q        <= '0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            enable_q     <= 1'b0;
            frame_done_q <= 1'b0;
            ima_q        <= '0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            enable_q     <= enable_d;
            frame_done_q <= frame_done_d;
            ima_q        <= ima_d;
        end
    end

    // Storage never reaches the outputs before it is rewritten, so it carries no reset.
    always_ff @(posedge clk) begin
        linebuf_q <= linebuf_d;
        win_q     <= win_d;
    end

    assign ima        = ima_q;
    assign enable     = enable_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;
    assign frame_done = frame_done_q;
    assign state_dbg  = state_q;
endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: an 8x8 and a 7x7 instance share one pixel stream; a frame-array model predicts windows.
module tb_conv_window_gen;
    localparam int IMA = 8;
    localparam int K   = 7;
    localparam int WB  = IMA * K * K;
`ifdef CONV_WIN_STRIDE2_EN
    localparam bit STRIDE2 = 1'b1;
`else
    localparam bit STRIDE2 = 1'b0;
`endif

    typedef struct packed {
        logic [WB-1:0] ima;
        logic [15:0]   row;
        logic [15:0]   col;
        logic          fd;
    } win_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    pix_in = '0;
    logic          pix_valid = 1'b0;
    logic          sof = 1'b0;

    logic [WB-1:0] ima8, ima7;
    logic          en8, en7, fd8, fd7;
    logic [15:0]   row8, col8, row7, col7;
    logic [1:0]    st8, st7;

    int checks = 0;
    int errors = 0;
    int n_en8 = 0, n_en7 = 0, n_fd8 = 0, n_fd7 = 0;

    win_t exp_q8[$];
    win_t exp_q7[$];
    int         m_w [2] = '{8, 7};
    int         m_h [2] = '{8, 7};
    bit         m_act [2];
    int         m_r [2];
    int         m_c [2];
    logic [7:0] img [2][8][8];

    always #5 clk = ~clk;

    conv_window_gen_if #(.IMA(IMA)) if8 ();
    conv_window_gen_if #(.IMA(IMA)) if7 ();
    assign if8.pix_in = pix_in;
    assign if8.pix_valid = pix_valid;
    assign if8.sof = sof;
    assign if7.pix_in = pix_in;
    assign if7.pix_valid = pix_valid;
    assign if7.sof = sof;

    conv_window_gen #(.IMA(IMA), .K(K), .IMG_W(8), .IMG_H(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .pix(if8.slave), .ima(ima8), .enable(en8),
        .out_row(row8), .out_col(col8), .frame_done(fd8), .state_dbg(st8)
    );
    conv_window_gen #(.IMA(IMA), .K(K), .IMG_W(7), .IMG_H(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .pix(if7.slave), .ima(ima7), .enable(en7),
        .out_row(row7), .out_col(col7), .frame_done(fd7), .state_dbg(st7)
    );

    task automatic chk(input string tag, input logic [WB-1:0] got, input logic [WB-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: the frame is kept as a 2D array and each window is read straight out of it.
    task automatic model_beat(input int m, input logic [7:0] p, input logic s);
        win_t e;
        int orow, ocol, lor, loc;
        if (s) begin
            m_act[m] = 1'b1;
            m_r[m] = 0;
            m_c[m] = 0;
        end
        if (!m_act[m]) return;
        img[m][m_r[m]][m_c[m]] = p;
        if (!s && m_r[m] >= K - 1 && m_c[m] >= K - 1) begin
            orow = m_r[m] - (K - 1);
            ocol = m_c[m] - (K - 1);
            lor = STRIDE2 ? ((m_h[m] - K) / 2) * 2 : m_h[m] - K;
            loc = STRIDE2 ? ((m_w[m] - K) / 2) * 2 : m_w[m] - K;
            if (!STRIDE2 || (orow % 2 == 0 && ocol % 2 == 0)) begin
                e = '0;
                for (int r = 0; r < K; r++)
                    for (int c = 0; c < K; c++)
                        e.ima[IMA*(r*K+c) +: IMA] = img[m][orow+r][ocol+c];
                e.row = 16'(orow);
                e.col = 16'(ocol);
                e.fd = (orow == lor) && (ocol == loc);
                if (m == 0) exp_q8.push_back(e);
                else        exp_q7.push_back(e);
            end
        end
        if (m_r[m] == m_h[m] - 1 && m_c[m] == m_w[m] - 1) m_act[m] = 1'b0;
        else if (m_c[m] == m_w[m] - 1) begin
            m_c[m] = 0;
            m_r[m]++;
        end else m_c[m]++;
    endtask

    task automatic cmp_win(input string nm, input bit have, input win_t e, input logic en,
                           input logic [WB-1:0] im, input logic [15:0] r, input logic [15:0] c,
                           input logic fd);
        chk({nm, "_enable"}, WB'(en), WB'(have));
        if (have && en) begin
            chk({nm, "_ima"}, im, e.ima);
            chk({nm, "_out_row"}, WB'(r), WB'(e.row));
            chk({nm, "_out_col"}, WB'(c), WB'(e.col));
            chk({nm, "_frame_done"}, WB'(fd), WB'(e.fd));
        end else if (!have) begin
            chk({nm, "_frame_done_idle"}, WB'(fd), WB'(1'b0));
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the edge against this cycle's expectations.
    task automatic tick();
        win_t e8, e7;
        bit h8, h7;
        @(posedge clk);
        #1;
        h8 = exp_q8.size() > 0;
        h7 = exp_q7.size() > 0;
        e8 = '0;
        e7 = '0;
        if (h8) e8 = exp_q8.pop_front();
        if (h7) e7 = exp_q7.pop_front();
        cmp_win("d8", h8, e8, en8, ima8, row8, col8, fd8);
        cmp_win("d7", h7, e7, en7, ima7, row7, col7, fd7);
        n_en8 += int'(en8);
        n_en7 += int'(en7);
        n_fd8 += int'(fd8);
        n_fd7 += int'(fd7);
    endtask

    task automatic beat(input logic [7:0] p, input logic s);
        pix_in = p;
        sof = s;
        pix_valid = 1'b1;
        if (rst_n) begin
            model_beat(0, p, s);
            model_beat(1, p, s);
        end
        tick();
        pix_valid = 1'b0;
        sof = 1'b0;
    endtask

    task automatic idle(input int n);
        pix_valid = 1'b0;
        sof = 1'b0;
        pix_in = 8'($urandom);
        repeat (n) tick();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ima8"}, ima8, '0);
        chk({tag, "_en8"}, WB'(en8), '0);
        chk({tag, "_row8"}, WB'(row8), '0);
        chk({tag, "_col8"}, WB'(col8), '0);
        chk({tag, "_fd8"}, WB'(fd8), '0);
        chk({tag, "_ima7"}, ima7, '0);
        chk({tag, "_en7"}, WB'(en7), '0);
        chk({tag, "_fd7"}, WB'(fd7), '0);
    endtask

    // mode 0: pixel = row*8+col; mode 1: random pixels. Gaps of 0..gap_max idle cycles between beats.
    task automatic frame8(input int mode, input int gap_max, input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            beat((mode == 0) ? 8'(i) : 8'($urandom), i == 0);
            if (gap_max > 0) idle($urandom_range(gap_max, 0));
        end
    endtask

    task automatic check_frame8(input string tag, input int n0, input int f0);
        idle(3);
        chk({tag, "_win_count"}, WB'(n_en8 - n0), STRIDE2 ? WB'(1) : WB'(4));
        chk({tag, "_fd_count"}, WB'(n_fd8 - f0), WB'(1));
    endtask

    initial begin
        int n0, f0;
        logic [WB-1:0] lanes;

        rst_n = 1'b0;
        repeat (5) begin
            pix_in = 8'($urandom);
            pix_valid = 1'($urandom);
            sof = 1'($urandom);
            tick();
            check_reset("rst_hold");
        end
        pix_valid = 1'b0;
        sof = 1'b0;
        rst_n = 1'b1;
        idle(2);
        for (int i = 0; i < 20; i++) beat(8'($urandom), 1'b0);
        idle(2);
        chk("no_sof_windows", WB'(n_en8 + n_en7), WB'(0));

        // 7x7 frame, pixel i = i: the single window has lane j = j.
        n0 = n_en7;
        for (int i = 0; i < 49; i++) beat(8'(i), i == 0);
        idle(3);
        chk("f7_win_count", WB'(n_en7 - n0), WB'(1));
        lanes = '0;
        for (int j = 0; j < K * K; j++) lanes[IMA*j +: IMA] = 8'(j);
        chk("f7_lanes", ima7, lanes);

        n0 = n_en8; f0 = n_fd8;
        frame8(0, 0, 64);
        check_frame8("f8_nogap", n0, f0);
        chk("f8_lane0", WB'(ima8[7:0]), STRIDE2 ? WB'(0) : WB'(9));
        chk("f8_lane48", WB'(ima8[WB-1 -: 8]), STRIDE2 ? WB'(54) : WB'(63));

        n0 = n_en8; f0 = n_fd8;
        frame8(0, 5, 64);
        check_frame8("f8_gaps", n0, f0);
        chk("f8g_lane0", WB'(ima8[7:0]), STRIDE2 ? WB'(0) : WB'(9));

        for (int i = 0; i < 10; i++) beat(8'($urandom), 1'b0);
        idle(2);

        // Abandon a frame at beat 30 by starting a new one.
        frame8(1, 0, 30);
        n0 = n_en8; f0 = n_fd8;
        frame8(1, 0, 64);
        check_frame8("f8_restart", n0, f0);

        // Asynchronous reset in the middle of a frame.
        frame8(1, 1, 45);
        rst_n = 1'b0;
        m_act[0] = 1'b0;
        m_act[1] = 1'b0;
        #1;
        check_reset("rst_async");
        idle(2);
        rst_n = 1'b1;
        idle(1);
        n0 = n_en8; f0 = n_fd8;
        frame8(1, 0, 64);
        check_frame8("f8_after_rst", n0, f0);

        for (int k = 0; k < 3; k++) begin
            n0 = n_en8; f0 = n_fd8;
            frame8(1, 3, 64);
            check_frame8("f8_rand", n0, f0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
